// File: rtl/control_merge_dataless_if.sv
// Handshake bundle for the dataless control merge: SIZE input tokens in,
// one merged token out plus the index of the input that supplied it.
interface control_merge_dataless_if #(
  parameter int SIZE        = 2,
  parameter int INDEX_WIDTH = 1
);
  logic [SIZE-1:0]        ins_valid;
  logic [SIZE-1:0]        ins_ready;
  logic                   outs_valid;
  logic                   outs_ready;
  logic [INDEX_WIDTH-1:0] index;
  logic                   index_valid;
  logic                   index_ready;

  modport slave (
    input  ins_valid,
    input  outs_ready,
    input  index_ready,
    output ins_ready,
    output outs_valid,
    output index,
    output index_valid
  );

  modport master (
    output ins_valid,
    output outs_ready,
    output index_ready,
    input  ins_ready,
    input  outs_valid,
    input  index,
    input  index_valid
  );
endinterface

// File: rtl/control_merge_dataless.sv
// Dataless control merge: arbitrate SIZE token inputs into one slot buffer that
// eagerly forks to outs and index. Define CMERGE_ROUND_ROBIN_EN for round-robin.
module control_merge_dataless #(
  parameter int SIZE        = 2,
  parameter int INDEX_WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  control_merge_dataless_if.slave   bus
);

  logic                   w_any;
  logic [INDEX_WIDTH-1:0] w_grant_idx;
  logic                   w_in_hs;
  logic                   w_fork_valid;
  logic [INDEX_WIDTH-1:0] w_fork_idx;
  logic                   w_outs_hs;
  logic                   w_index_hs;
  logic                   w_complete;

  logic                   r_full;
  logic [INDEX_WIDTH-1:0] r_idx;
  logic                   r_sent_outs;
  logic                   r_sent_index;

  assign w_any = |bus.ins_valid;

`ifdef CMERGE_ROUND_ROBIN_EN
  logic [INDEX_WIDTH-1:0] r_last;

  // Scan backwards so the first valid input after r_last is the final winner.
  always_comb begin
    int j;
    j           = 0;
    w_grant_idx = '0;
    for (int k = SIZE - 1; k >= 0; k--) begin
      j = int'(r_last) + 1 + k;
      if (j >= SIZE) begin
        j = j - SIZE;
      end
      if (bus.ins_valid[j]) begin
        w_grant_idx = INDEX_WIDTH'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= INDEX_WIDTH'(SIZE - 1);
    end else if (w_in_hs) begin
      r_last <= w_grant_idx;
    end
  end
`else
  always_comb begin
    w_grant_idx = '0;
    for (int k = SIZE - 1; k >= 0; k--) begin
      if (bus.ins_valid[k]) begin
        w_grant_idx = INDEX_WIDTH'(k);
      end
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_ready
      assign bus.ins_ready[gi] = w_any && !r_full && (w_grant_idx == INDEX_WIDTH'(gi));
    end
  endgenerate

  // The buffer is transparent while empty, so a token can fork in its arrival cycle.
  assign w_in_hs      = w_any && !r_full;
  assign w_fork_valid = r_full || w_any;
  assign w_fork_idx   = r_full ? r_idx : w_grant_idx;

  assign bus.outs_valid  = w_fork_valid && !r_sent_outs;
  assign bus.index_valid = w_fork_valid && !r_sent_index;
  assign bus.index       = w_fork_idx;

  assign w_outs_hs  = bus.outs_valid && bus.outs_ready;
  assign w_index_hs = bus.index_valid && bus.index_ready;
  assign w_complete = w_fork_valid
                      && (r_sent_outs || bus.outs_ready)
                      && (r_sent_index || bus.index_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full       <= 1'b0;
      r_idx        <= '0;
      r_sent_outs  <= 1'b0;
      r_sent_index <= 1'b0;
    end else begin
      if (w_in_hs && !w_complete) begin
        r_full <= 1'b1;
        r_idx  <= w_grant_idx;
      end else if (r_full && w_complete) begin
        r_full <= 1'b0;
      end

      if (w_fork_valid && !w_complete) begin
        r_sent_outs  <= r_sent_outs || w_outs_hs;
        r_sent_index <= r_sent_index || w_index_hs;
      end else begin
        r_sent_outs  <= 1'b0;
        r_sent_index <= 1'b0;
      end
    end
  end

endmodule

// File: doc/control_merge_dataless.md
CONTROL_MERGE_DATALESS -- requirements
Module: control_merge_dataless

Interface
REQ-001 Parameter SIZE, default 2: number of dataless input channels, legal range 2..16.
REQ-002 Parameter INDEX_WIDTH, default 1: width of index output; SHALL satisfy 2^INDEX_WIDTH >= SIZE.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ins_valid  input  SIZE  per-input token valid.
REQ-006 ins_ready  output  SIZE  per-input ready; asserted only for the granted input.
REQ-007 outs_valid  output  1  merged control token valid.
REQ-008 outs_ready  input  1  merged token consumer ready.
REQ-009 index  output  INDEX_WIDTH  number of the input that supplied the current token.
REQ-010 index_valid  output  1  index token valid.
REQ-011 index_ready  input  1  index consumer ready.

Function
REQ-012 Arbiter SHALL grant exactly one valid input per cycle, or none if no ins_valid bit is set; in default mode, the lowest-numbered valid input wins.
REQ-013 Input i handshake SHALL occur when ins_valid[i] && ins_ready[i]; ins_ready[i] = grant[i] && !full.
REQ-014 One-slot transparent buffer: while empty (full=0), fork input valid = any ins_valid and fork input index = granted index (0-cycle latency); while full, fork input valid = 1 and fork input index = stored index.
REQ-015 Buffer SHALL load (full<=1, store granted index) when an input handshake occurs and the fork does not complete in the same cycle; it SHALL clear (full<=0) when the fork completes while full.
REQ-016 Eager fork: outs_valid = fork_valid && !sent_outs; index_valid = fork_valid && !sent_index.
REQ-017 Fork completes when (sent_outs || outs_ready) && (sent_index || index_ready) and fork_valid is set.
REQ-018 sent_x flags: if fork_valid && !complete, sent_x <= sent_x | (x_valid && x_ready); otherwise sent_x <= 0.
REQ-019 Each token SHALL be delivered exactly once on outs and exactly once on index, in the same order as input handshakes; no token is lost or duplicated.
REQ-020 Simultaneous valid inputs: the losers SHALL see ins_ready=0 and SHALL remain pending; they are served in later cycles.
REQ-021 Full buffer: all ins_ready SHALL be 0 until the fork completes; an input may hand off in the cycle after the buffer clears.
REQ-022 index SHALL stay stable while index_valid=1 and the token is not yet accepted.
REQ-023 Throughput: with both consumers always ready, one token per cycle.

Reset
REQ-024 rst low SHALL immediately clear full, sent_outs, sent_index and the stored index to 0, independent of clk.
REQ-025 During and after reset with all ins_valid=0: outs_valid=0, index_valid=0, ins_ready=0, index=0.
REQ-026 Reset asserted mid-transfer SHALL discard any buffered or partially forked token.
REQ-027 In round-robin mode, reset SHALL set the last-grant pointer to SIZE-1, so input 0 has priority first.

Configuration
REQ-028 Macro CMERGE_ROUND_ROBIN_EN.
- Defined: priority search starts at (last_grant+1) mod SIZE, and last_grant updates to the granted index on each input handshake.
- Undefined: fixed lowest-index priority; no pointer register exists.
- Both modes: all other requirements unchanged.

Verification
REQ-029 SIZE=2, ins_valid=2'b11 held for 2 cycles, both readys=1 -> default mode: index 0 then 0 (input 1 starved); CMERGE_ROUND_ROBIN_EN: index 0 then 1.
REQ-030 ins_valid=2'b10, outs_ready=1, index_ready=0 for 3 cycles then 1 -> outs handshake in cycle 0 only; index=1 held valid until cycle 3; ins_ready=0 in cycles 1-3.
REQ-031 Buffer empty, ins_valid=2'b01, outs_ready=0, index_ready=0 -> input handshake in cycle 0, full=1 at cycle 1, ins_ready=2'b00 until both consumers accept.
REQ-032 SIZE=4, ins_valid=4'b1111 continuously, both readys=1 -> one token per cycle; round-robin index sequence 0,1,2,3,0.
REQ-033 rst driven low asynchronously while full=1 and sent_outs=1 -> outs_valid=0 and index_valid=0 without a clock edge; after release, the next token has both outputs fresh.
REQ-034 Random valid/ready stimulus for 10k cycles -> outs count == index count == input handshake count, and index order matches input handshake order.
